// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one multi-cycle binary-to-BCD converter
// among numReq requesters. A request is granted for one LOAD cycle, the
// converter is given convLatency cycles, and the captured result is returned
// to the granted requester with a one-cycle rspValid pulse.
//
// Optional feature: define BCD_ARB_RANGE_CHECK_EN to reject operands that do
// not fit in numberOfDigits BCD digits. Such an operand is still granted, but
// the converter is not started and the requester gets rspErr=1 with a zero
// result one cycle later. Without the macro every operand is converted.
//
// state | meaning
// IDLE  | no transaction; pick next requester round-robin from rrPtr
// LOAD  | one cycle: gnt to the selected requester, converter load strobe
// WAIT  | convLatency cycles for the converter result
// DONE  | one cycle: rspValid to the served requester, advance rrPtr

module bcd_conv_arbiter #(
   parameter int numReq            = 4,
   parameter int binaryNumberWidth = 32,
   parameter int busWidth          = 4,
   parameter int numberOfDigits    = 3,
   parameter int convLatency       = 34
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [numReq-1:0]                         req,
   input  logic [numReq-1:0][binaryNumberWidth-1:0]  reqNumber,
   output logic [numReq-1:0]                         gnt,
   output logic [numReq-1:0]                         rspValid,
   output logic [numberOfDigits-1:0][busWidth-1:0]   rspDecimal,
   output logic                                      rspErr,
   output logic                                      busy,
   output logic                                      conv_load,
   output logic [binaryNumberWidth-1:0]              conv_binaryNumber,
   input  logic [numberOfDigits-1:0][busWidth-1:0]   conv_BinaryDecimal
);

   localparam int IDXW = (numReq > 1) ? $clog2(numReq) : 1;
   localparam int CNTW = (convLatency > 1) ? $clog2(convLatency) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]                              state_q, state_d;
   logic [IDXW-1:0]                         rr_q, rr_d;
   logic [IDXW-1:0]                         idx_q, idx_d;
   logic [CNTW-1:0]                         cnt_q, cnt_d;
   logic [binaryNumberWidth-1:0]            op_q, op_d;
   logic [numberOfDigits-1:0][busWidth-1:0] dec_q, dec_d;
   logic                                    err_q, err_d;

   logic            sel_found;
   logic [IDXW-1:0] sel_idx;
   logic [IDXW-1:0] cand;
   logic            range_err;

   // First pending requester at or after the round-robin pointer, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < numReq; i++) begin
         cand = IDXW'((int'(rr_q) + i) % numReq);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

`ifdef BCD_ARB_RANGE_CHECK_EN
   localparam logic [binaryNumberWidth-1:0] MAX_OPERAND =
      binaryNumberWidth'(10**numberOfDigits - 1);
   assign range_err = (reqNumber[sel_idx] > MAX_OPERAND);
`else
   assign range_err = 1'b0;
`endif

   // Next-state logic for the transaction FSM and its datapath registers.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      dec_d   = dec_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               idx_d   = sel_idx;
               op_d    = reqNumber[sel_idx];
               err_d   = range_err;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d = '0;
            if (err_q) begin
               // Rejected operand: skip the converter, report a zero result.
               dec_d   = '0;
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNTW'(convLatency - 1)) begin
               dec_d   = conv_BinaryDecimal;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            rr_d    = (idx_q == IDXW'(numReq - 1)) ? '0 : idx_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         dec_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         dec_q   <= dec_d;
         err_q   <= err_d;
      end
   end

   // One-hot grant and response pulses decoded from state and served index.
   always_comb begin
      gnt      = '0;
      rspValid = '0;
      if (state_q == S_LOAD) gnt[idx_q] = 1'b1;
      if (state_q == S_DONE) rspValid[idx_q] = 1'b1;
   end

   assign busy              = (state_q != S_IDLE);
   assign conv_load         = (state_q == S_LOAD) && !err_q;
   assign conv_binaryNumber = op_q;
   assign rspDecimal        = dec_q;

`ifdef BCD_ARB_RANGE_CHECK_EN
   assign rspErr = (state_q == S_DONE) && err_q;
`else
   assign rspErr = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioural converter model.
module tb_bcd_conv_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int B  = 4;
   localparam int D  = 3;
   localparam int L  = 34;
   localparam int DW = D * B;
   localparam longint unsigned MAXV = 999;
`ifdef BCD_ARB_RANGE_CHECK_EN
   localparam bit RANGE = 1'b1;
`else
   localparam bit RANGE = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [N-1:0]        req;
   logic [N-1:0][W-1:0] reqNumber;
   logic [N-1:0]        gnt, rspValid;
   logic [D-1:0][B-1:0] rspDecimal, conv_BinaryDecimal;
   logic                rspErr, busy, conv_load;
   logic [W-1:0]        conv_binaryNumber;

   logic [N-1:0] drop_en;
   logic         rand_en;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bcd_conv_arbiter #(
      .numReq(N), .binaryNumberWidth(W), .busWidth(B),
      .numberOfDigits(D), .convLatency(L)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .reqNumber(reqNumber),
      .gnt(gnt), .rspValid(rspValid), .rspDecimal(rspDecimal),
      .rspErr(rspErr), .busy(busy), .conv_load(conv_load),
      .conv_binaryNumber(conv_binaryNumber),
      .conv_BinaryDecimal(conv_BinaryDecimal)
   );

   function automatic logic [DW-1:0] to_bcd(input logic [W-1:0] v);
      longint unsigned x;
      logic [DW-1:0]   r;
      x = v;
      r = '0;
      for (int d = 0; d < D; d++) begin
         r[d*B +: B] = B'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Converter model: correct BCD from the L-th cycle after the load strobe.
   logic [W-1:0] cv_val;
   int           cv_rem;
   bit           cv_have;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cv_val <= '0; cv_rem <= 0; cv_have <= 1'b0;
      end else if (conv_load) begin
         cv_val <= conv_binaryNumber; cv_rem <= L - 1; cv_have <= 1'b1;
      end else if (cv_rem > 0) begin
         cv_rem <= cv_rem - 1;
      end
   end
   assign conv_BinaryDecimal = (cv_have && cv_rem == 0) ? to_bcd(cv_val) : {D{4'hE}};

   // Scoreboard and reference model.
   typedef struct {
      int            idx;
      logic [DW-1:0] dec;
      bit            err;
      int            due;
   } exp_t;
   exp_t                sb[$];
   int                  glog[$];
   logic [N-1:0]        prev_req = '0;
   logic [N-1:0][W-1:0] prev_op  = '0;
   int                  rr_m = 0;
   int                  cyc  = 0;
   logic [DW-1:0]       last_dec = '0;
   int                  m_sel, m_j;
   bit                  m_err;
   logic [W-1:0]        m_op;
   exp_t                m_x;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb.delete();
         rr_m     = 0;
         last_dec = '0;
      end else begin
         if (gnt != '0) begin
            m_sel = -1;
            for (int k = 0; k < N; k++) begin
               m_j = (rr_m + k) % N;
               if (m_sel < 0 && prev_req[m_j]) m_sel = m_j;
            end
            if (m_sel < 0) begin
               check("gnt_without_request", gnt, 0);
            end else begin
               m_op  = prev_op[m_sel];
               m_err = RANGE && (longint'(m_op) > MAXV);
               check("gnt_index", gnt, 64'(1) << m_sel);
               check("load_operand", conv_binaryNumber, m_op);
               check("load_strobe", conv_load, !m_err);
               check("result_held", rspDecimal, last_dec);
               m_x.idx = m_sel;
               m_x.dec = m_err ? '0 : to_bcd(m_op);
               m_x.err = m_err;
               m_x.due = cyc + (m_err ? 1 : L + 1);
               sb.push_back(m_x);
               glog.push_back(m_sel);
               rr_m = (m_sel + 1) % N;
            end
         end
         if (rspValid != '0) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", rspValid, 0);
            end else begin
               m_x = sb.pop_front();
               check("rsp_valid_idx", rspValid, 64'(1) << m_x.idx);
               check("rsp_decimal", rspDecimal, m_x.dec);
               check("rsp_err", rspErr, m_x.err);
               check("rsp_latency", cyc, m_x.due);
               last_dec = m_x.dec;
            end
         end
      end
      prev_req = req;
      prev_op  = reqNumber;
   end

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(7))
         0:       return $urandom;
         1:       return W'(999 + $urandom_range(2));
         default: return W'($urandom_range(999));
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (req[i] && gnt[i] && drop_en[i]) begin
            req[i]       = 1'b0;
            reqNumber[i] = $urandom;
         end else if (rand_en && !req[i] && $urandom_range(15) == 0) begin
            req[i]       = 1'b1;
            reqNumber[i] = rand_op();
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_rspValid", rspValid, 0);
      check("rst_rspDecimal", rspDecimal, 0);
      check("rst_rspErr", rspErr, 0);
      check("rst_busy", busy, 0);
      check("rst_conv_load", conv_load, 0);
      check("rst_conv_operand", conv_binaryNumber, 0);
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_quiet(input int max);
      int n = 0;
      while ((req != '0 || busy) && n < max) begin
         step();
         n++;
      end
      check("quiet_timeout", (req != '0 || busy), 0);
      repeat (2) step();
   endtask

   task automatic wait_gnt(input int i, input int max);
      int n = 0;
      while (!gnt[i] && n < max) begin
         step();
         n++;
      end
      check("gnt_timeout", gnt[i], 1);
   endtask

   int exp_c[4] = '{0, 1, 2, 3};
   int exp_f[4] = '{0, 2, 0, 2};
   int cnt2, n;

   initial begin
      req = '0; reqNumber = '0; drop_en = '1; rand_en = 1'b0;
      do_reset();

      // Single request
      glog.delete();
      req[0] = 1'b1; reqNumber[0] = 11;
      wait_gnt(0, 20);
      check("single_conv_load", conv_load, 1);
      check("single_operand", conv_binaryNumber, 11);
      wait_quiet(100);
      check("single_digits", rspDecimal, 12'h011);
      check("single_count", glog.size(), 1);

      // Contention after reset
      do_reset();
      glog.delete();
      for (int i = 0; i < N; i++) reqNumber[i] = W'(i + 1);
      req = '1;
      wait_quiet(400);
      check("contention_count", glog.size(), 4);
      for (int k = 0; k < 4 && k < glog.size(); k++) check("contention_order", glog[k], exp_c[k]);

      // Fairness with two held requesters
      do_reset();
      glog.delete();
      drop_en = 4'b1010;
      req[0] = 1'b1; reqNumber[0] = 100;
      req[2] = 1'b1; reqNumber[2] = 202;
      n = 0;
      while (glog.size() < 4 && n < 400) begin step(); n++; end
      req = '0;
      drop_en = '1;
      wait_quiet(100);
      check("fair_count", glog.size(), 4);
      for (int k = 0; k < 4 && k < glog.size(); k++) check("fair_order", glog[k], exp_f[k]);

      // Withdrawn request while busy
      glog.delete();
      req[0] = 1'b1; reqNumber[0] = 500;
      wait_gnt(0, 20);
      repeat (5) step();
      req[2] = 1'b1; reqNumber[2] = 222;
      step();
      req[2] = 1'b0;
      wait_quiet(100);
      cnt2 = 0;
      foreach (glog[k]) if (glog[k] == 2) cnt2++;
      check("withdrawn_gnt2", cnt2, 0);

      // Reset in the middle of requester 1's wait
      req[1] = 1'b1; reqNumber[1] = 77;
      wait_gnt(1, 20);
      repeat (5) step();
      req[1] = 1'b1; reqNumber[1] = 55;
      req[3] = 1'b1; reqNumber[3] = 33;
      glog.delete();
      do_reset();
      wait_quiet(200);
      check("post_reset_count", glog.size(), 2);
      if (glog.size() >= 2) begin
         check("post_reset_first", glog[0], 1);
         check("post_reset_second", glog[1], 3);
      end

      // Range boundary
      req[1] = 1'b1; reqNumber[1] = 1000;
      wait_quiet(100);
      req[1] = 1'b1; reqNumber[1] = 999;
      wait_quiet(100);
      check("boundary_999", rspDecimal, 12'h999);

      // Random traffic
      rand_en = 1'b1;
      repeat (1500) step();
      rand_en = 1'b0;
      wait_quiet(600);
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
